uart_rx_deser: RTL

UART_RX_DESER -- requirements
Module: uart_rx_deser

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_rx_deser.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive deserializer.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  localparam int BRK_BIT = 10;
  localparam int FE_BIT  = 9;
  localparam int PE_BIT  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: reloads from baud_div and ticks when the count hits zero.
module uart_baud_gen (
  input  logic        sys_clk,
  input  logic        sys_rstn,
  input  logic [15:0] baud_div,
  input  logic        en,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;

  // baud_div is sampled only on reload, so a change lands at the next period boundary
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == 16'd0) begin
      cnt_d = baud_div;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  assign tick = en && (cnt_q == 16'd0);

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receiver: synchronizes rx_in, deserializes one character and pushes {brk, fe, pe, data}.
// Define UART_RX_PARITY_EN to build the optional parity bit and parity check.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rstn,
  input  logic        rx_en,
  input  logic        rx_in,
  input  logic [15:0] baud_div,
  input  logic [1:0]  char_len,
  input  logic        parity_en,
  input  logic        parity_odd,
  input  logic        fifo_full,
  output logic        fifo_push,
  output logic [10:0] fifo_din,
  output logic        overrun,
  output logic        rx_busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] FULL = OS_W'(OVERSAMPLE - 1);

  logic            rx_meta_q, rx_s_q;
  logic            tick;
  rx_state_e       state_q, state_d;
  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      data_q, data_d;
  logic            par_acc_q, par_acc_d;
  logic            any_one_q, any_one_d;
  logic            pend_q, pend_d;
  logic [10:0]     frame_q, frame_d;
  logic [10:0]     last_q, last_d;
  logic            rx_busy_q;
  logic            pe_bit;
  logic            last_bit;

  uart_baud_gen u_baud_gen (
    .sys_clk  (sys_clk),
    .sys_rstn (sys_rstn),
    .baud_div (baud_div),
    .en       (rx_en),
    .tick     (tick)
  );

`ifdef UART_RX_PARITY_EN
  assign pe_bit = parity_en & (par_acc_q ^ parity_odd);
`else
  logic unused_parity;
  assign unused_parity = parity_en ^ parity_odd ^ par_acc_q;
  assign pe_bit = 1'b0;
`endif

  assign last_bit = (bit_cnt_q == ({1'b0, char_len} + 3'd4));

  // The finished character waits one cycle in frame_q; fifo_full is judged in the push cycle itself
  assign fifo_push = pend_q & rx_en & ~fifo_full;
  assign overrun   = pend_q & rx_en & fifo_full;
  assign fifo_din  = fifo_push ? frame_q : last_q;
  assign rx_busy   = rx_busy_q;

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    par_acc_d = par_acc_q;
    any_one_d = any_one_q;
    frame_d   = frame_q;
    pend_d    = 1'b0;
    last_d    = fifo_push ? frame_q : last_q;

    case (state_q)
      IDLE: begin
        os_cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (tick) begin
          if (os_cnt_q == HALF) begin
            os_cnt_d = '0;
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              bit_cnt_d = '0;
              data_d    = '0;
              par_acc_d = 1'b0;
              any_one_d = 1'b0;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_cnt_q == FULL) begin
            os_cnt_d          = '0;
            data_d[bit_cnt_q] = rx_s_q;
            par_acc_d         = par_acc_q ^ rx_s_q;
            any_one_d         = any_one_q | rx_s_q;
            bit_cnt_d         = bit_cnt_q + 3'd1;
            if (last_bit) begin
`ifdef UART_RX_PARITY_EN
              state_d = parity_en ? PARITY : STOP;
`else
              state_d = STOP;
`endif
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (os_cnt_q == FULL) begin
            os_cnt_d  = '0;
            par_acc_d = par_acc_q ^ rx_s_q;
            any_one_d = any_one_q | rx_s_q;
            state_d   = STOP;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (os_cnt_q == FULL) begin
            os_cnt_d         = '0;
            pend_d           = 1'b1;
            frame_d[7:0]     = data_q;
            frame_d[PE_BIT]  = pe_bit;
            frame_d[FE_BIT]  = ~rx_s_q;
            frame_d[BRK_BIT] = ~any_one_q & ~rx_s_q;
            state_d          = rx_s_q ? IDLE : WAIT_HIGH;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!rx_en) begin
      state_d  = IDLE;
      os_cnt_d = '0;
      pend_d   = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      par_acc_q <= 1'b0;
      any_one_q <= 1'b0;
      pend_q    <= 1'b0;
      frame_q   <= '0;
      last_q    <= '0;
      rx_busy_q <= 1'b0;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      par_acc_q <= par_acc_d;
      any_one_q <= any_one_d;
      pend_q    <= pend_d;
      frame_q   <= frame_d;
      last_q    <= last_d;
      rx_busy_q <= (state_d != IDLE);
    end
  end

endmodule
